// File: rtl/warp_fetch_issuer_if.sv
// Fetch-side handshake bundle: imem request channel plus the warp-ID burst to the branch unit.
// The master drives the imem request and ID burst; update_queue_valid doubles as the per-beat ready.
interface warp_fetch_issuer_if #(
  parameter int NUM_WARPS = 32
);
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic             m_tvalid_imem;
  logic             m_tready_imem;
  logic [31:0]      imem_addr;
  logic [WID_W-1:0] imem_warp_id;
  logic [31:0]      imem_pred;
  logic             m_tvalid_bu;
  logic             m_tlast_bu;
  logic [WID_W-1:0] m_warp_id_bu;
  logic             update_queue_valid;

  modport master (
    output m_tvalid_imem,
    input  m_tready_imem,
    output imem_addr,
    output imem_warp_id,
    output imem_pred,
    output m_tvalid_bu,
    output m_tlast_bu,
    output m_warp_id_bu,
    input  update_queue_valid
  );

  modport slave (
    input  m_tvalid_imem,
    output m_tready_imem,
    input  imem_addr,
    input  imem_warp_id,
    input  imem_pred,
    input  m_tvalid_bu,
    input  m_tlast_bu,
    input  m_warp_id_bu,
    output update_queue_valid
  );
endinterface

// File: rtl/warp_fetch_issuer.sv
// Round-robin warp fetch issuer: snapshots eligible warps, issues up to MAX_BATCH imem requests (1/cycle),
// then replays the issued IDs as a tlast burst to the branch unit; all outputs registered, held under backpressure.
module warp_fetch_issuer #(
  parameter int NUM_WARPS = 32,
  parameter int MAX_BATCH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WARPS-1:0] i_warp_active,
  input  logic [NUM_WARPS-1:0] i_warp_stall,
  input  logic [31:0]          i_next_pc [NUM_WARPS],
  input  logic [31:0]          i_pred    [NUM_WARPS],
  warp_fetch_issuer_if.master  io_fetch,
  output logic                 o_busy
);

  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CNT_W = $clog2(MAX_BATCH + 1);
  localparam int IDX_W = (MAX_BATCH > 1) ? $clog2(MAX_BATCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_SEND  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WID_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [IDX_W-1:0]     r_beat;
  logic [NUM_WARPS-1:0] r_snap;
  logic [WID_W-1:0]     r_buf [MAX_BATCH];

  logic                 r_imem_vld;
  logic [31:0]          r_imem_addr;
  logic [WID_W-1:0]     r_imem_id;
  logic [31:0]          r_imem_pred;
  logic                 r_bu_vld;
  logic                 r_bu_last;
  logic [WID_W-1:0]     r_bu_id;
  logic                 r_busy;

  logic                 w_imem_vld_nxt;
  logic [31:0]          w_imem_addr_nxt;
  logic [WID_W-1:0]     w_imem_id_nxt;
  logic [31:0]          w_imem_pred_nxt;
  logic                 w_bu_vld_nxt;
  logic                 w_bu_last_nxt;
  logic [WID_W-1:0]     w_bu_id_nxt;
  logic [IDX_W-1:0]     w_beat_nxt;

  logic [NUM_WARPS-1:0] w_elig;
  logic                 w_uqv;
  logic                 w_xfer;
  logic                 w_beat;
  logic                 w_start;
  logic                 w_first_found;
  logic [WID_W-1:0]     w_first_id;
  logic                 w_next_found;
  logic [WID_W-1:0]     w_next_id;
  logic [NUM_WARPS-1:0] w_snap_left;
  logic [WID_W-1:0]     w_id_inc;
  logic [CNT_W-1:0]     w_count_inc;
  logic                 w_batch_done;
  logic [IDX_W-1:0]     w_beat_inc;

  // Lowest set bit at or after 'start', wrapping modulo NUM_WARPS; returns {found, index}.
  function automatic logic [WID_W:0] f_pick(input logic [NUM_WARPS-1:0] mask,
                                            input logic [WID_W-1:0]     start);
    logic             found;
    logic [WID_W-1:0] idx;
    logic [WID_W-1:0] jj;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      j = int'(start) + i;
      if (j >= NUM_WARPS) j = j - NUM_WARPS;
      jj = WID_W'(j);
      if (!found && mask[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    return {found, idx};
  endfunction

  assign w_elig      = i_warp_active & ~i_warp_stall;
  assign w_uqv       = io_fetch.update_queue_valid;
  assign w_xfer      = r_imem_vld & io_fetch.m_tready_imem;
  assign w_beat      = r_bu_vld & w_uqv;
  assign w_snap_left = r_snap & ~(NUM_WARPS'(1) << r_imem_id);
  assign w_id_inc    = (r_imem_id == WID_W'(NUM_WARPS - 1)) ? '0 : r_imem_id + WID_W'(1);
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_beat_inc  = r_beat + IDX_W'(1);

  assign {w_first_found, w_first_id} = f_pick(w_elig, r_rr_ptr);
  assign {w_next_found,  w_next_id}  = f_pick(w_snap_left, w_id_inc);

  assign w_start      = (r_state == S_IDLE) & w_uqv & w_first_found;
  assign w_batch_done = (w_count_inc == CNT_W'(MAX_BATCH)) | ~w_next_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)                 w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_xfer && w_batch_done)  w_state_nxt = S_SEND;
      S_SEND:  if (w_beat && r_bu_last)     w_state_nxt = S_WAIT;
      S_WAIT:  if (w_uqv)                   w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_imem_vld_nxt  = r_imem_vld;
    w_imem_addr_nxt = r_imem_addr;
    w_imem_id_nxt   = r_imem_id;
    w_imem_pred_nxt = r_imem_pred;
    w_bu_vld_nxt    = r_bu_vld;
    w_bu_last_nxt   = r_bu_last;
    w_bu_id_nxt     = r_bu_id;
    w_beat_nxt      = r_beat;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_imem_vld_nxt  = 1'b1;
          w_imem_id_nxt   = w_first_id;
          w_imem_addr_nxt = i_next_pc[w_first_id];
          w_imem_pred_nxt = i_pred[w_first_id];
        end
      end
      S_ISSUE: begin
        if (w_xfer) begin
          if (w_batch_done) begin
            // The buffer write for this transfer lands on the same edge, so beat 0 may bypass it.
            w_imem_vld_nxt = 1'b0;
            w_bu_vld_nxt   = 1'b1;
            w_bu_last_nxt  = (r_count == '0);
            w_bu_id_nxt    = (r_count == '0) ? r_imem_id : r_buf[0];
            w_beat_nxt     = '0;
          end else begin
            w_imem_id_nxt   = w_next_id;
            w_imem_addr_nxt = i_next_pc[w_next_id];
            w_imem_pred_nxt = i_pred[w_next_id];
          end
        end
      end
      S_SEND: begin
        if (w_beat) begin
          if (r_bu_last) begin
            w_bu_vld_nxt  = 1'b0;
            w_bu_last_nxt = 1'b0;
          end else begin
            w_beat_nxt    = w_beat_inc;
            w_bu_id_nxt   = r_buf[w_beat_inc];
            w_bu_last_nxt = ((CNT_W'(w_beat_inc) + CNT_W'(1)) == r_count);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imem_vld  <= 1'b0;
      r_imem_addr <= '0;
      r_imem_id   <= '0;
      r_imem_pred <= '0;
      r_bu_vld    <= 1'b0;
      r_bu_last   <= 1'b0;
      r_bu_id     <= '0;
      r_beat      <= '0;
      r_busy      <= 1'b0;
      r_snap      <= '0;
      r_count     <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_imem_vld  <= w_imem_vld_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_imem_id   <= w_imem_id_nxt;
      r_imem_pred <= w_imem_pred_nxt;
      r_bu_vld    <= w_bu_vld_nxt;
      r_bu_last   <= w_bu_last_nxt;
      r_bu_id     <= w_bu_id_nxt;
      r_beat      <= w_beat_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: if (w_start) r_snap <= w_elig;
        S_ISSUE: begin
          if (w_xfer) begin
            r_snap   <= w_snap_left;
            r_count  <= w_count_inc;
            r_rr_ptr <= w_id_inc;
          end
        end
        S_SEND: if (w_beat && r_bu_last) r_count <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_ISSUE && w_xfer) r_buf[r_count[IDX_W-1:0]] <= r_imem_id;
  end

  assign io_fetch.m_tvalid_imem = r_imem_vld;
  assign io_fetch.imem_addr     = r_imem_addr;
  assign io_fetch.imem_warp_id  = r_imem_id;
  assign io_fetch.imem_pred     = r_imem_pred;
  assign io_fetch.m_tvalid_bu   = r_bu_vld;
  assign io_fetch.m_tlast_bu    = r_bu_last;
  assign io_fetch.m_warp_id_bu  = r_bu_id;
  assign o_busy                 = r_busy;

endmodule

// File: tb/tb_warp_fetch_issuer.sv
// Bench for warp_fetch_issuer: randomized handshakes against a rotation-scan batch model.
module tb_warp_fetch_issuer;
  localparam int NW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NW-1:0] act;
  logic [NW-1:0] stl;
  logic [31:0]   npc [NW];
  logic [31:0]   prd [NW];
  logic          rdy;
  logic          uqv;
  logic          busy;

  always #5 clk = ~clk;

  warp_fetch_issuer_if #(.NUM_WARPS(NW)) fif ();
  assign fif.m_tready_imem      = rdy;
  assign fif.update_queue_valid = uqv;

  warp_fetch_issuer #(.NUM_WARPS(NW), .MAX_BATCH(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_warp_active (act),
    .i_warp_stall  (stl),
    .i_next_pc     (npc),
    .i_pred        (prd),
    .io_fetch      (fif),
    .o_busy        (busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_rr = 0;
  int          exp_q [$];
  int          q_id [$];
  logic [31:0] q_addr [$];
  logic [31:0] q_pred [$];
  int          q_icyc [$];
  int          q_bid [$];
  logic        q_blast [$];
  int          q_bcyc [$];
  int          hold_err;
  int          tmo;
  int          rdy_pct = 100;
  int          uqv_pct = 100;

  // Expected batch: walk warps in rotation order from the round-robin pointer, take up to MB eligible.
  task automatic model_batch(input logic [NW-1:0] mask);
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      int j;
      j = (m_rr + i) % NW;
      if (mask[j] && exp_q.size() < MB) exp_q.push_back(j);
    end
    if (exp_q.size() > 0) m_rr = (exp_q[exp_q.size()-1] + 1) % NW;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; rdy = 1'b0; uqv = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
  endtask

  task automatic randomize_pcs();
    for (int i = 0; i < NW; i++) begin
      npc[i] = $urandom & 32'hFFFF_FFFC;
      prd[i] = $urandom;
    end
  endtask

  // Drives one batch with randomized ready/uqv, recording transfers, beats and hold violations.
  task automatic collect(input int max_cyc, input int late_stall, input int hold_id);
    logic        p_iv, p_ir, p_bv, p_bu, p_blast, started, seen_last;
    logic [31:0] p_addr, p_pred;
    logic [4:0]  p_id, p_bid;
    int          n, holds;
    q_id.delete(); q_addr.delete(); q_pred.delete(); q_icyc.delete();
    q_bid.delete(); q_blast.delete(); q_bcyc.delete();
    hold_err = 0; tmo = 0; n = 0; holds = 0;
    started = 1'b0; seen_last = 1'b0; p_iv = 1'b0; p_ir = 1'b0; p_bv = 1'b0; p_bu = 1'b0;
    p_addr = '0; p_pred = '0; p_id = '0; p_bid = '0; p_blast = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (p_iv && !p_ir && (fif.m_tvalid_imem !== 1'b1 || fif.imem_addr !== p_addr ||
                            fif.imem_warp_id !== p_id || fif.imem_pred !== p_pred)) hold_err++;
      if (p_bv && !p_bu && (fif.m_tvalid_bu !== 1'b1 || fif.m_warp_id_bu !== p_bid ||
                            fif.m_tlast_bu !== p_blast)) hold_err++;
      if (busy && !started) begin
        started = 1'b1;
        if (late_stall >= 0) stl[late_stall] = 1'b1;
      end
      if (started && seen_last && !busy) begin rdy = 1'b0; uqv = 1'b0; break; end
      if (n > max_cyc) begin tmo = 1; rdy = 1'b0; uqv = 1'b0; break; end
      rdy = ($urandom_range(99) < rdy_pct);
      uqv = ($urandom_range(99) < uqv_pct);
      if (fif.m_tvalid_imem && int'(fif.imem_warp_id) == hold_id && holds < 3) begin
        rdy = 1'b0; holds++;
      end
      if (fif.m_tvalid_imem && rdy) begin
        q_id.push_back(int'(fif.imem_warp_id)); q_addr.push_back(fif.imem_addr);
        q_pred.push_back(fif.imem_pred); q_icyc.push_back(n);
      end
      if (fif.m_tvalid_bu && uqv) begin
        q_bid.push_back(int'(fif.m_warp_id_bu)); q_blast.push_back(fif.m_tlast_bu); q_bcyc.push_back(n);
        if (fif.m_tlast_bu) seen_last = 1'b1;
      end
      p_iv = fif.m_tvalid_imem; p_ir = rdy; p_addr = fif.imem_addr; p_id = fif.imem_warp_id;
      p_pred = fif.imem_pred; p_bv = fif.m_tvalid_bu; p_bu = uqv; p_bid = fif.m_warp_id_bu;
      p_blast = fif.m_tlast_bu;
    end
  endtask

  task automatic test_reset();
    logic [77:0] outv;
    rst_n = 1'b0; rdy = 1'b0; uqv = 1'b0; act = '1; stl = '0;
    repeat (2) @(negedge clk);
    outv = {fif.m_tvalid_imem, fif.imem_addr, fif.imem_warp_id, fif.imem_pred,
            fif.m_tvalid_bu, fif.m_tlast_bu, fif.m_warp_id_bu, busy};
    checks++;
    if (outv !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outv); end
    rst_n = 1'b1; m_rr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, fif.m_tvalid_imem} !== 2'b00) begin
      errors++; $display("FAIL reset_idle_no_uqv got busy=%b vld=%b want 0 0", busy, fif.m_tvalid_imem);
    end
  endtask

  task automatic test_basic();
    randomize_pcs();
    act = '0; act[0] = 1'b1; act[3] = 1'b1; act[7] = 1'b1; stl = '0;
    npc[0] = 32'h100; npc[3] = 32'h200; npc[7] = 32'h300;
    rdy_pct = 100; uqv_pct = 100;
    model_batch(act & ~stl);
    collect(100, -1, -1);
    checks++;
    if (tmo !== 0 || q_id.size() !== 3 || q_bid.size() !== 3) begin
      errors++; $display("FAIL t1_sizes got tmo=%0d imem=%0d bu=%0d want 0 3 3", tmo, q_id.size(), q_bid.size());
    end
    for (int i = 0; i < exp_q.size() && i < q_id.size(); i++) begin
      checks++;
      if (q_id[i] !== exp_q[i] || q_addr[i] !== npc[exp_q[i]] || q_pred[i] !== prd[exp_q[i]] ||
          q_icyc[i] !== q_icyc[0] + i) begin
        errors++; $display("FAIL t1_imem[%0d] got id=%0d addr=%h cyc=%0d want id=%0d addr=%h cyc=%0d",
                           i, q_id[i], q_addr[i], q_icyc[i], exp_q[i], npc[exp_q[i]], q_icyc[0] + i);
      end
    end
    for (int i = 0; i < exp_q.size() && i < q_bid.size(); i++) begin
      checks++;
      if (q_bid[i] !== exp_q[i] || q_blast[i] !== (i == exp_q.size() - 1)) begin
        errors++; $display("FAIL t1_bu[%0d] got id=%0d last=%b want id=%0d last=%b",
                           i, q_bid[i], q_blast[i], exp_q[i], (i == exp_q.size() - 1));
      end
    end
    if (q_bcyc.size() > 0 && q_icyc.size() == 3) begin
      checks++;
      if (q_bcyc[0] !== q_icyc[2] + 1) begin
        errors++; $display("FAIL t1_send_latency got cyc=%0d want %0d", q_bcyc[0], q_icyc[2] + 1);
      end
    end
  endtask

  task automatic test_full_batches();
    apply_reset();
    randomize_pcs();
    act = '1; stl = '0; rdy_pct = 100; uqv_pct = 100;
    for (int b = 0; b < 2; b++) begin
      model_batch(act & ~stl);
      collect(200, -1, -1);
      checks++;
      if (tmo !== 0 || q_id.size() !== MB || q_bid.size() !== MB) begin
        errors++; $display("FAIL t2_b%0d_sizes got tmo=%0d imem=%0d bu=%0d want 0 %0d %0d",
                           b, tmo, q_id.size(), q_bid.size(), MB, MB);
      end
      for (int i = 0; i < MB && i < q_id.size() && i < q_bid.size(); i++) begin
        checks++;
        if (q_id[i] !== b * MB + i || q_addr[i] !== npc[b * MB + i] || q_bid[i] !== b * MB + i ||
            q_blast[i] !== (i == MB - 1)) begin
          errors++; $display("FAIL t2_b%0d[%0d] got imem=%0d bu=%0d last=%b want %0d last=%b",
                             b, i, q_id[i], q_bid[i], q_blast[i], b * MB + i, (i == MB - 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    randomize_pcs();
    act = '0; act[0] = 1'b1; act[3] = 1'b1; act[7] = 1'b1; stl = '0;
    npc[3] = 32'h200;
    rdy_pct = 100; uqv_pct = 100;
    model_batch(act & ~stl);
    collect(100, -1, 3);
    checks++;
    if (tmo !== 0 || hold_err !== 0 || q_id.size() !== 3) begin
      errors++; $display("FAIL t3_hold got tmo=%0d hold_err=%0d n=%0d want 0 0 3", tmo, hold_err, q_id.size());
    end
    if (q_id.size() == 3) begin
      checks++;
      if (q_id[1] !== 3 || q_addr[1] !== 32'h200 || q_icyc[1] - q_icyc[0] !== 4 || q_id[2] !== 7) begin
        errors++; $display("FAIL t3_single_xfer got id=%0d addr=%h gap=%0d next=%0d want 3 200 4 7",
                           q_id[1], q_addr[1], q_icyc[1] - q_icyc[0], q_id[2]);
      end
    end
  endtask

  task automatic test_uqv();
    randomize_pcs();
    act = $urandom | 32'h1; stl = '0; uqv = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, fif.m_tvalid_imem} !== 2'b00) begin
        errors++; $display("FAIL t4_idle_gate[%0d] got busy=%b vld=%b want 0 0", i, busy, fif.m_tvalid_imem);
      end
    end
    rdy_pct = 100; uqv_pct = 40;
    model_batch(act & ~stl);
    collect(400, -1, -1);
    checks++;
    if (tmo !== 0 || hold_err !== 0 || q_bid.size() !== exp_q.size()) begin
      errors++; $display("FAIL t4_burst got tmo=%0d hold_err=%0d beats=%0d want 0 0 %0d",
                         tmo, hold_err, q_bid.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q_bid.size(); i++) begin
      checks++;
      if (q_bid[i] !== exp_q[i] || q_blast[i] !== (i == exp_q.size() - 1)) begin
        errors++; $display("FAIL t4_bu[%0d] got id=%0d last=%b want id=%0d", i, q_bid[i], q_blast[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    randomize_pcs();
    act = '0; act[1] = 1'b1; act[5] = 1'b1; act[9] = 1'b1; act[12] = 1'b1;
    stl = '0; stl[5] = 1'b1;
    rdy_pct = 100; uqv_pct = 100;
    model_batch(act & ~stl);
    collect(100, 9, -1);
    checks++;
    if (tmo !== 0 || q_id.size() !== exp_q.size()) begin
      errors++; $display("FAIL t5_size got tmo=%0d n=%0d want 0 %0d", tmo, q_id.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < q_id.size(); i++) begin
      checks++;
      if (q_id[i] !== exp_q[i]) begin
        errors++; $display("FAIL t5_id[%0d] got %0d want %0d", i, q_id[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    rdy_pct = 60; uqv_pct = 60;
    for (int b = 0; b < 8; b++) begin
      int k;
      randomize_pcs();
      act = $urandom; stl = $urandom & $urandom;
      if ((act & ~stl) == '0) begin
        k = $urandom_range(NW - 1); act[k] = 1'b1; stl[k] = 1'b0;
      end
      model_batch(act & ~stl);
      collect(600, -1, -1);
      checks++;
      if (tmo !== 0 || hold_err !== 0 || q_id.size() !== exp_q.size() || q_bid.size() !== exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_shape got tmo=%0d hold=%0d imem=%0d bu=%0d want 0 0 %0d",
                           b, tmo, hold_err, q_id.size(), q_bid.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < q_id.size() && i < q_bid.size(); i++) begin
        checks++;
        if (q_id[i] !== exp_q[i] || q_addr[i] !== npc[exp_q[i]] || q_pred[i] !== prd[exp_q[i]] ||
            q_bid[i] !== exp_q[i] || q_blast[i] !== (i == exp_q.size() - 1)) begin
          errors++; $display("FAIL rnd%0d[%0d] got id=%0d addr=%h bu=%0d last=%b want id=%0d addr=%h",
                             b, i, q_id[i], q_addr[i], q_bid[i], q_blast[i], exp_q[i], npc[exp_q[i]]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [77:0] outv;
    int          n;
    apply_reset();
    randomize_pcs();
    act = '0; act[12] = 1'b1; act[20] = 1'b1; stl = '0;
    rdy = 1'b1; uqv = 1'b1; n = 0;
    while (fif.m_tvalid_bu !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL t6_reach_send got timeout want bu valid"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    outv = {fif.m_tvalid_imem, fif.imem_addr, fif.imem_warp_id, fif.imem_pred,
            fif.m_tvalid_bu, fif.m_tlast_bu, fif.m_warp_id_bu, busy};
    checks++;
    if (outv !== '0) begin errors++; $display("FAIL t6_async_clear got %h want 0", outv); end
    uqv = 1'b0; rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_rr = 0;
    act = '0; act[0] = 1'b1; act[10] = 1'b1; act[20] = 1'b1; act[25] = 1'b1;
    rdy_pct = 100; uqv_pct = 100;
    model_batch(act & ~stl);
    collect(100, -1, -1);
    checks++;
    if (tmo !== 0 || q_bid.size() !== 4 || q_id.size() !== 4) begin
      errors++; $display("FAIL t6_fresh_size got tmo=%0d imem=%0d bu=%0d want 0 4 4", tmo, q_id.size(), q_bid.size());
    end
    for (int i = 0; i < exp_q.size() && i < q_bid.size() && i < q_id.size(); i++) begin
      checks++;
      if (q_id[i] !== exp_q[i] || q_bid[i] !== exp_q[i]) begin
        errors++; $display("FAIL t6_fresh[%0d] got imem=%0d bu=%0d want %0d", i, q_id[i], q_bid[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b0; uqv = 1'b0; act = '0; stl = '0;
    for (int i = 0; i < NW; i++) begin npc[i] = '0; prd[i] = '0; end
    test_reset();
    test_basic();
    test_full_batches();
    test_backpressure();
    test_uqv();
    test_stall();
    test_random();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
